// File: rtl/microwave_control_if.sv
// Front-panel and timer signals of the microwave controller, bundled so the
// controller and its environment connect through a single port.
interface microwave_control_if;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic       timer_en;
  logic       timer_loadn;
  logic       timer_clearn;
  logic       mag_on;
  logic       beep;
  logic [1:0] state;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done,
    input  timer_en, timer_loadn, timer_clearn, mag_on, beep, state
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done,
    output timer_en, timer_loadn, timer_clearn, mag_on, beep, state
  );
endinterface

// File: rtl/microwave_control.sv
// Microwave oven controller: synchronizes the front-panel buttons and door
// sensor, turns presses into single pulses and sequences cook/pause/done.
module microwave_control #(
  parameter int BEEP_CYCLES = 8
) (
  input logic               clock,
  input logic               reset,
  microwave_control_if.slave io
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COOKING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [7:0] BEEP_LOAD = 8'(BEEP_CYCLES - 1);

  // Button vectors are ordered {clear, stop, start}.
  logic [2:0] btn_meta, btn_sync, btn_prev, btn_armed;
  logic [1:0] settle;
  logic       door_meta, door_sync;
  logic [2:0] press;
  logic       start_p, stop_p, clear_p;

  state_t     state_q, state_d;
  logic [7:0] beep_cnt_q, beep_cnt_d;
  logic       clear_act;
  logic       mag_on_q, timer_en_q, timer_loadn_q, timer_clearn_q, beep_q;

  // A button only becomes armed once a genuine released level has come through
  // the synchronizer after reset, so a button held through reset never pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_meta  <= '1;
      btn_sync  <= '1;
      btn_prev  <= '1;
      btn_armed <= '0;
      settle    <= '0;
      door_meta <= 1'b0;
      door_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the value from
      // before the edge; blocking ones would collapse the 2-flop chain to one.
      btn_meta  <= {io.clearn, io.stopn, io.startn};
      btn_sync  <= btn_meta;
      btn_prev  <= btn_sync;
      settle    <= {settle[0], 1'b1};
      btn_armed <= btn_armed | (btn_sync & {3{settle[1]}});
      door_meta <= io.door_closed;
      door_sync <= door_meta;
    end
  end

  assign press   = btn_armed & btn_prev & ~btn_sync;
  assign start_p = press[0];
  assign stop_p  = press[1];
  assign clear_p = press[2];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    beep_cnt_d = beep_cnt_q;
    clear_act  = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_p) clear_act = 1'b1;
        if (start_p && door_sync && !io.timer_done) state_d = COOKING;
      end
      COOKING: begin
        if (!door_sync)         state_d = PAUSED;
        else if (io.timer_done) state_d = DONE;
        else if (stop_p)        state_d = PAUSED;
      end
      PAUSED: begin
        if (stop_p || clear_p) begin
          state_d   = IDLE;
          clear_act = 1'b1;
        end else if (start_p && door_sync && !io.timer_done) begin
          state_d = COOKING;
        end
      end
      DONE: begin
        if (|press || beep_cnt_q == 8'd0) state_d = IDLE;
        else                              beep_cnt_d = beep_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) beep_cnt_d = BEEP_LOAD;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and stay glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      beep_cnt_q     <= 8'd0;
      mag_on_q       <= 1'b0;
      timer_en_q     <= 1'b0;
      timer_loadn_q  <= 1'b0;
      timer_clearn_q <= 1'b1;
      beep_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      beep_cnt_q     <= beep_cnt_d;
      mag_on_q       <= (state_d == COOKING);
      timer_en_q     <= (state_d == COOKING);
      timer_loadn_q  <= (state_d != IDLE);
      timer_clearn_q <= ~clear_act;
      beep_q         <= (state_d == DONE);
    end
  end

  assign io.state        = state_q;
  assign io.mag_on       = mag_on_q;
  assign io.timer_en     = timer_en_q;
  assign io.timer_loadn  = timer_loadn_q;
  assign io.timer_clearn = timer_clearn_q;
  assign io.beep         = beep_q;

endmodule

// File: tb/tb_microwave_control.sv
// Scoreboard bench for microwave_control: stimulus queues each expected output
// change with its cycle; a monitor compares every change the DUT makes.
module tb_microwave_control;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  microwave_control_if bus ();

  microwave_control #(.BEEP_CYCLES(8)) dut (
    .clock (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {state, mag_on, timer_en, timer_loadn, timer_clearn, beep}
  localparam logic [6:0] O_IDLE     = 7'b00_0_0_0_1_0;
  localparam logic [6:0] O_IDLE_CLR = 7'b00_0_0_0_0_0;
  localparam logic [6:0] O_COOK     = 7'b01_1_1_1_1_0;
  localparam logic [6:0] O_PAUSE    = 7'b10_0_0_1_1_0;
  localparam logic [6:0] O_DONE     = 7'b11_0_0_1_1_1;

  localparam logic [2:0] START = 3'b001;
  localparam logic [2:0] STOP  = 3'b010;
  localparam logic [2:0] CLEAR = 3'b100;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] out;
  } exp_t;

  exp_t sb[$];

  logic [6:0] outs;
  assign outs = {bus.state, bus.mag_on, bus.timer_en, bus.timer_loadn,
                 bus.timer_clearn, bus.beep};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_rel(input string name, input int d, input logic [6:0] o);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + d;
    e.out  = o;
    sb.push_back(e);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    {bus.clearn, bus.stopn, bus.startn} = ~mask;
    repeat (hold) @(negedge clk);
    {bus.clearn, bus.stopn, bus.startn} = 3'b111;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: any change of the output vector must match the next queued entry.
  logic [6:0] last;
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      last = outs;
    end else if (outs !== last) begin
      if (sb.size() == 0) begin
        check("unexpected_change", {25'd0, outs}, {25'd0, last});
      end else begin
        e = sb.pop_front();
        check({e.name, "_out"}, {25'd0, outs}, {25'd0, e.out});
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
      last = outs;
    end
  end

  initial begin
    reset           = 1'b1;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b0;
    bus.timer_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, outs}, {25'd0, O_IDLE});
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);

    // Start ignored with door open, then with timer already at zero.
    press(START, 2);
    bus.door_closed = 1'b1;
    repeat (4) @(negedge clk);
    bus.timer_done = 1'b1;
    press(START, 2);
    bus.timer_done = 1'b0;

    exp_rel("start_cook", 3, O_COOK);
    press(START, 3);
    press(CLEAR, 2);
    press(START, 2);

    exp_rel("door_open_pause", 3, O_PAUSE);
    bus.door_closed = 1'b0;
    repeat (6) @(negedge clk);
    press(START, 2);
    bus.door_closed = 1'b1;
    repeat (4) @(negedge clk);

    exp_rel("resume", 3, O_COOK);
    press(START, 2);
    exp_rel("stop_pause", 3, O_PAUSE);
    press(STOP, 2);

    exp_rel("stop_start_clr", 3, O_IDLE_CLR);
    exp_rel("stop_start_idle", 4, O_IDLE);
    press(STOP | START, 2);

    exp_rel("clear_held_clr", 3, O_IDLE_CLR);
    exp_rel("clear_held_end", 4, O_IDLE);
    press(CLEAR, 50);

    // Normal end of cook: beep lasts eight cycles.
    exp_rel("cook2", 3, O_COOK);
    press(START, 2);
    exp_rel("done", 1, O_DONE);
    exp_rel("done_expire", 9, O_IDLE);
    bus.timer_done = 1'b1;
    @(negedge clk);
    bus.timer_done = 1'b0;
    repeat (12) @(negedge clk);

    // Door open beats timer_done.
    exp_rel("cook3", 3, O_COOK);
    press(START, 2);
    exp_rel("door_over_done", 3, O_PAUSE);
    bus.door_closed = 1'b0;
    repeat (2) @(negedge clk);
    bus.timer_done = 1'b1;
    @(negedge clk);
    bus.timer_done  = 1'b0;
    bus.door_closed = 1'b1;
    repeat (4) @(negedge clk);

    // timer_done beats stop; then a button aborts the beep early.
    exp_rel("cook4", 3, O_COOK);
    press(START, 2);
    exp_rel("done_over_stop", 3, O_DONE);
    bus.stopn = 1'b0;
    repeat (2) @(negedge clk);
    bus.timer_done = 1'b1;
    @(negedge clk);
    bus.timer_done = 1'b0;
    bus.stopn      = 1'b1;
    @(negedge clk);
    exp_rel("done_abort", 3, O_IDLE);
    bus.startn = 1'b0;
    @(negedge clk);
    bus.startn = 1'b1;
    repeat (8) @(negedge clk);

    // Reset mid-cook with start held through and after reset.
    exp_rel("cook5", 3, O_COOK);
    press(START, 2);
    exp_rel("reset_cook", 1, O_IDLE);
    bus.startn = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    bus.startn = 1'b1;
    repeat (4) @(negedge clk);
    exp_rel("cook6", 3, O_COOK);
    press(START, 2);

    // Reset mid-done.
    exp_rel("done2", 1, O_DONE);
    exp_rel("reset_done", 3, O_IDLE);
    bus.timer_done = 1'b1;
    @(negedge clk);
    bus.timer_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microwave_control.md
MICROWAVE_CONTROL -- requirements
Module: microwave_control

Interface
REQ-001 Parameter BEEP_CYCLES, default 8: number of clock cycles the DONE state holds before returning to IDLE; legal range 1..255.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 startn  input  1  start button, active-low, asynchronous to clock.
REQ-005 stopn  input  1  stop/pause button, active-low, asynchronous to clock.
REQ-006 clearn  input  1  clear button, active-low, asynchronous to clock.
REQ-007 door_closed  input  1  door sensor: 1 = closed, asynchronous to clock.
REQ-008 timer_done  input  1  countdown timer reached 00:00; same clock domain, level.
REQ-009 timer_en  output  1  count enable to the downstream timer.
REQ-010 timer_loadn  output  1  active-low load to the timer; while low, the timer accepts keypad digits.
REQ-011 timer_clearn  output  1  active-low clear to the timer; one-cycle pulse.
REQ-012 mag_on  output  1  magnetron drive.
REQ-013 beep  output  1  end-of-cook indicator.
REQ-014 state  output  2  current state code, for debug and display.

Function
REQ-015 startn, stopn, clearn and door_closed SHALL each pass through a 2-flop synchronizer; timer_done SHALL NOT be synchronized.
REQ-016 Each synchronized button SHALL drive a falling-edge detector producing a one-cycle press pulse; holding a button low SHALL yield exactly one pulse.
REQ-017 A button first sampled low at edge N SHALL cause its state transition at edge N+2.
REQ-018 States and codes: IDLE=00, COOKING=01, PAUSED=10, DONE=11.
REQ-019 IDLE -> COOKING on a start pulse when door_closed_sync=1 and timer_done=0; a start pulse is ignored otherwise.
REQ-020 IDLE: a clear pulse SHALL assert timer_clearn low for exactly the next cycle; the state remains IDLE.
REQ-021 COOKING -> PAUSED when door_closed_sync=0 or on a stop pulse; COOKING -> DONE when timer_done=1.
REQ-022 Priority in COOKING: door open > timer_done > stop; start and clear pulses are ignored.
REQ-023 PAUSED -> COOKING on a start pulse when door_closed_sync=1 and timer_done=0.
REQ-024 PAUSED -> IDLE on a stop or clear pulse, with a one-cycle timer_clearn low pulse; stop/clear takes priority over start in the same cycle.
REQ-025 DONE: an 8-bit counter loads BEEP_CYCLES-1 on entry and decrements each cycle; at 0 the FSM goes to IDLE.
REQ-026 DONE: any button pulse SHALL force IDLE on the next edge.
REQ-027 Moore outputs, registered: mag_on=timer_en=1 only in COOKING; timer_loadn=0 only in IDLE; beep=1 only in DONE.
REQ-028 timer_clearn SHALL be 1 except during the single cycle after a clear action.

Reset
REQ-029 reset=1 at a rising edge SHALL clear state to IDLE, synchronizer and edge-detector flops to idle (buttons released, door open), beep counter to 0, and outputs to mag_on=0, timer_en=0, timer_loadn=0, timer_clearn=1, beep=0.
REQ-030 reset SHALL dominate all other inputs, including mid-COOKING and mid-DONE; no press pulse SHALL be generated from a button already held low when reset releases.

Verification
REQ-031 Door closed, timer_done=0, startn low from edge 10 -> state=01 and mag_on=timer_en=1 after edge 12; timer_loadn=1.
REQ-032 COOKING, door_closed dropped at edge 20 -> state=10 and mag_on=0 after edge 22; then startn pressed with the door still open -> remains 10.
REQ-033 COOKING, timer_done=1 at edge 30 -> state=11 and beep=1 from edge 31 for 8 cycles; state=00 and timer_loadn=0 after edge 39.
REQ-034 PAUSED, stopn and startn pressed in the same cycle -> state=00, timer_clearn low for exactly one cycle.
REQ-035 IDLE, clearn held low for 50 cycles -> exactly one timer_clearn low cycle; the state stays 00.
REQ-036 COOKING, reset=1 for one edge -> all outputs at their reset values after that edge; startn held low through reset -> no transition until it is released and pressed again.
